// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code constants and state type shared by the convolutional encoder and the Viterbi decoder.
package viterbi_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int MEM_W = K - 1;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: encoder shift memory plus generator parities for the bit currently presented.
module conv_enc_core #(
  parameter int K = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         b_i,
  output logic [1:0]   sym_o,
  output logic [K-2:0] mem_o
);
  logic [K-2:0] mem_q;
  logic [K-1:0] w;
  assign w = {b_i, mem_q};
  assign sym_o = {^(w & G0), ^(w & G1)};
  assign mem_o = mem_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else if (shift_i) mem_q <= w[K-1:1];
  end
endmodule

// File: rtl/conv_encoder_framed.sv
// conv_encoder_framed: rate-1/2 convolutional encoder that closes every FRAME_LEN-bit frame with K-1 zero tail bits.
module conv_encoder_framed
  import viterbi_pkg::enc_state_t, viterbi_pkg::IDLE, viterbi_pkg::DATA, viterbi_pkg::TAIL;
#(
  parameter int K = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1,
  parameter int FRAME_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       frame_done_o
);
  localparam int CW = (FRAME_LEN < 1) ? 1 : $clog2(FRAME_LEN + 1);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);
  localparam logic [TW-1:0] TL = TW'(K - 2);
  enc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic valid_q, done_q;
  logic [1:0] dout_q, sym;
  logic [K-2:0] mem;
  logic accept, shift, last_tail;
  assign ready_o = state_q != TAIL;
  assign accept = enable_i & ready_o;
  assign last_tail = (state_q == TAIL) && (tcnt_q == TL);
  assign shift = accept | (state_q == TAIL);
  conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk(clk), .rst(rst), .shift_i(shift), .b_i(accept & d_in), .sym_o(sym), .mem_o(mem)
  );
  // Count stays at 0 in IDLE, so every accept is a plain increment.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tcnt_d = tcnt_q;
    if (state_q == TAIL) begin
      tcnt_d = last_tail ? '0 : tcnt_q + 1'b1;
      cnt_d = last_tail ? '0 : cnt_q;
      state_d = last_tail ? IDLE : TAIL;
    end else if (accept && FRAME_LEN == 0) begin
      state_d = DATA;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == FL) ? TAIL : DATA;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tcnt_q <= '0;
      valid_q <= 1'b0;
      dout_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      valid_q <= shift;
      dout_q <= shift ? sym : dout_q;
      done_q <= last_tail;
    end
  end
  // The tail must leave the trellis in state 0 for the decoder's traceback.
  always_comb if (done_q) assert (mem == '0);
  assign valid_o = valid_q;
  assign d_out = dout_q;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_conv_encoder_framed.sv
// tb_conv_encoder_framed: directed vector tables for framed mode, reset corner cases and a streaming reference model.
module tb_conv_encoder_framed;
  logic clk = 1'b0, rst = 1'b0;
  logic en4 = 1'b0, d4 = 1'b0, en0 = 1'b0, d0 = 1'b0;
  logic rdy4, vld4, done4, rdy0, vld0, done0;
  logic [1:0] out4, out0;
  int errs = 0, checks = 0;
  typedef struct {
    logic en;
    logic din;
    logic v;
    logic [1:0] q;
    logic dn;
    logic rd;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  conv_encoder_framed #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .enable_i(en4), .d_in(d4), .ready_o(rdy4),
    .valid_o(vld4), .d_out(out4), .frame_done_o(done4)
  );
  conv_encoder_framed #(.FRAME_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .enable_i(en0), .d_in(d0), .ready_o(rdy0),
    .valid_o(vld0), .d_out(out0), .frame_done_o(done0)
  );
  function automatic vec_t mk(logic en, logic din, logic v, logic [1:0] q, logic dn, logic rd);
    vec_t r;
    r.en = en; r.din = din; r.v = v; r.q = q; r.dn = dn; r.rd = rd;
    return r;
  endfunction
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: {valid,d_out,done,ready} got %b want %b", name, act, exp);
    end
  endtask
  task automatic step4(input logic en, input logic din);
    @(negedge clk);
    en4 = en; d4 = din;
    @(posedge clk);
    #1;
  endtask
  task automatic step0(input logic en, input logic din);
    @(negedge clk);
    en0 = en; d0 = din;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic p1, p2, b, e;
    logic [1:0] last;
    // frame of 1,0,1,1 back to back
    tbl.push_back(mk(1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b00, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b01, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2'b11, 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'b11, 0, 1));
    // same frame with a gap after the second bit
    tbl.push_back(mk(1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b00, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b01, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2'b11, 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'b11, 0, 1));
    // enable held high through the tail, then a second frame 1,0,0,0
    tbl.push_back(mk(1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b00, 0, 1));
    tbl.push_back(mk(1, 1, 1, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2'b11, 1, 1));
    tbl.push_back(mk(1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2'b00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 1, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("reset4", {vld4, out4, done4, 1'b0}, 5'b00000);
    chk("reset0", {vld0, out0, done0, 1'b0}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", {3'b000, rdy4, rdy0}, 5'b00011);
    foreach (tbl[i]) begin
      step4(tbl[i].en, tbl[i].din);
      chk($sformatf("row%0d", i), {vld4, out4, done4, rdy4}, {tbl[i].v, tbl[i].q, tbl[i].dn, tbl[i].rd});
    end
    // reset asserted during the first tail cycle
    step4(1, 1); step4(1, 0); step4(1, 1); step4(1, 1);
    chk("pre_tail", {vld4, out4, done4, rdy4}, 5'b10100);
    en4 = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset", {vld4, out4, done4, 1'b0}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    step4(1, 1);
    chk("post_reset_bit", {vld4, out4, done4, rdy4}, 5'b11101);
    step4(0, 0);
    chk("no_partial_tail", {vld4, out4, done4, rdy4}, 5'b01101);
    // streaming mode: directed then against a history-based model
    step0(1, 1);
    chk("stream0", {vld0, out0, done0, rdy0}, 5'b11101);
    step0(1, 1);
    chk("stream1", {vld0, out0, done0, rdy0}, 5'b10101);
    step0(1, 1);
    chk("stream2", {vld0, out0, done0, rdy0}, 5'b11001);
    p1 = 1'b1; p2 = 1'b1; last = 2'b10;
    for (int i = 0; i < 80; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      step0(e, b);
      if (e) begin
        last = {b ^ p1 ^ p2, b ^ p2};
        p2 = p1;
        p1 = b;
      end
      chk($sformatf("rand%0d", i), {vld0, out0, done0, rdy0}, {e, last, 1'b0, 1'b1});
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
